// File: rtl/motion_vector_encoder.sv
// MPEG-2 motion vector encoder: codes one (h, v) vector against its predictors into
// motion_code VLC + motion_residual bits, packed MSB-first into 32-bit words.
module motion_vector_encoder #(
    parameter int H_R_SIZE = 3,
    parameter int V_R_SIZE = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic signed [31:0] in_pred_h,
    input  logic signed [31:0] in_pred_v,
    input  logic signed [31:0] in_mv_h,
    input  logic signed [31:0] in_mv_v,
    input  logic               mvscale,
    input  logic               emit_mvfs,
    input  logic               mvfs,
    input  logic               flush,
    output logic               busy,
    output logic [31:0]        out_word,
    output logic [5:0]         out_nbits,
    output logic               out_word_valid,
    output logic signed [31:0] out_pred_h,
    output logic signed [31:0] out_pred_v,
    output logic               done
);

    typedef enum logic [3:0] {
        S_IDLE, S_MVFS, S_H_CALC, S_H_CODE, S_H_RES,
        S_V_CALC, S_V_CODE, S_V_RES, S_DONE
    } state_t;

    typedef struct packed {
        logic [31:0] recon;
        logic        neg;
        logic [4:0]  mag;
        logic [7:0]  res;
    } calc_t;

    typedef struct packed {
        logic [4:0]  len;
        logic [15:0] bits;
    } vlc_t;

    // Delta wrap, motion_code magnitude/sign, residual and wrapped reconstruction.
    function automatic calc_t calc(input logic signed [31:0] pred,
                                   input logic signed [31:0] mv,
                                   input int r);
        logic signed [33:0] f, lo, hi, d, rc;
        logic [33:0] m1;
        calc_t c;
        f  = 34'sd1 <<< r;
        lo = -(f <<< 4);
        hi = (f <<< 4) - 34'sd1;
        d  = 34'(mv) - 34'(pred);
        if (d < lo)      d = d + (f <<< 5);
        else if (d > hi) d = d - (f <<< 5);
        rc = 34'(pred) + d;
        if (rc < lo)      rc = rc + (f <<< 5);
        else if (rc > hi) rc = rc - (f <<< 5);
        m1 = (d < 0) ? 34'(-d - 34'sd1) : 34'(d - 34'sd1);
        c.recon = 32'(rc);
        c.neg   = (d < 0);
        c.mag   = (d == 0) ? 5'd0 : 5'((m1 >> r) + 34'd1);
        c.res   = (d == 0) ? 8'd0 : 8'(m1 & 34'(f - 34'sd1));
        return c;
    endfunction

    function automatic vlc_t vlc(input logic [4:0] mag, input logic neg);
        logic [4:0] l;
        logic [9:0] v;
        vlc_t o;
        case (mag)
            5'd1:    begin l = 5'd2;  v = 10'd1;  end
            5'd2:    begin l = 5'd3;  v = 10'd1;  end
            5'd3:    begin l = 5'd4;  v = 10'd1;  end
            5'd4:    begin l = 5'd6;  v = 10'd3;  end
            5'd5:    begin l = 5'd7;  v = 10'd5;  end
            5'd6:    begin l = 5'd7;  v = 10'd4;  end
            5'd7:    begin l = 5'd7;  v = 10'd3;  end
            5'd8:    begin l = 5'd9;  v = 10'd11; end
            5'd9:    begin l = 5'd9;  v = 10'd10; end
            5'd10:   begin l = 5'd9;  v = 10'd9;  end
            5'd11:   begin l = 5'd10; v = 10'd17; end
            5'd12:   begin l = 5'd10; v = 10'd16; end
            5'd13:   begin l = 5'd10; v = 10'd15; end
            5'd14:   begin l = 5'd10; v = 10'd14; end
            5'd15:   begin l = 5'd10; v = 10'd13; end
            default: begin l = 5'd10; v = 10'd12; end
        endcase
        if (mag == 5'd0) begin
            o.len  = 5'd1;
            o.bits = 16'd1;
        end else begin
            o.len  = l + 5'd1;
            o.bits = 16'({v, neg});
        end
        return o;
    endfunction

    state_t state_q, state_d;
    logic [63:0] acc_q, acc_d, acc_b;
    logic [6:0]  fill_q, fill_d, fill_b;
    logic [31:0] out_word_q, out_word_d;
    logic [5:0]  out_nbits_q, out_nbits_d;
    logic        out_word_valid_q, out_word_valid_d;
    logic signed [31:0] out_pred_h_q, out_pred_h_d, out_pred_v_q, out_pred_v_d;
    logic        done_q, done_d;
    logic signed [31:0] pred_h_q, pred_h_d, pred_v_q, pred_v_d;
    logic signed [31:0] mv_h_q, mv_h_d, mv_v_q, mv_v_d;
    logic        mvscale_q, mvscale_d, emit_q, emit_d, mvfs_q, mvfs_d;
    logic        neg_q, neg_d;
    logic [4:0]  mag_q, mag_d;
    logic [7:0]  res_q, res_d;
    logic [15:0] app_bits;
    logic [4:0]  app_n;
    calc_t       calc_res;
    vlc_t        vlc_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            acc_q            <= '0;
            fill_q           <= '0;
            out_word_q       <= '0;
            out_nbits_q      <= '0;
            out_word_valid_q <= 1'b0;
            out_pred_h_q     <= '0;
            out_pred_v_q     <= '0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            acc_q            <= acc_d;
            fill_q           <= fill_d;
            out_word_q       <= out_word_d;
            out_nbits_q      <= out_nbits_d;
            out_word_valid_q <= out_word_valid_d;
            out_pred_h_q     <= out_pred_h_d;
            out_pred_v_q     <= out_pred_v_d;
            done_q           <= done_d;
        end
    end

    // Latched operands and per-component code state carry no reset.
    always_ff @(posedge clk) begin
        pred_h_q  <= pred_h_d;
        pred_v_q  <= pred_v_d;
        mv_h_q    <= mv_h_d;
        mv_v_q    <= mv_v_d;
        mvscale_q <= mvscale_d;
        emit_q    <= emit_d;
        mvfs_q    <= mvfs_d;
        neg_q     <= neg_d;
        mag_q     <= mag_d;
        res_q     <= res_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (in_valid) state_d = S_MVFS;
            S_MVFS:   state_d = S_H_CALC;
            S_H_CALC: state_d = S_H_CODE;
            S_H_CODE: state_d = S_H_RES;
            S_H_RES:  state_d = S_V_CALC;
            S_V_CALC: state_d = S_V_CODE;
            S_V_CODE: state_d = S_V_RES;
            S_V_RES:  state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pred_h_d     = pred_h_q;
        pred_v_d     = pred_v_q;
        mv_h_d       = mv_h_q;
        mv_v_d       = mv_v_q;
        mvscale_d    = mvscale_q;
        emit_d       = emit_q;
        mvfs_d       = mvfs_q;
        neg_d        = neg_q;
        mag_d        = mag_q;
        res_d        = res_q;
        out_pred_h_d = out_pred_h_q;
        out_pred_v_d = out_pred_v_q;
        done_d       = (state_q == S_DONE);

        if (state_q == S_IDLE && in_valid) begin
            pred_h_d  = in_pred_h;
            mv_h_d    = in_mv_h;
            pred_v_d  = mvscale ? (in_pred_v >>> 1) : in_pred_v;
            mv_v_d    = mvscale ? (in_mv_v >>> 1) : in_mv_v;
            mvscale_d = mvscale;
            emit_d    = emit_mvfs;
            mvfs_d    = mvfs;
        end

        if (state_q == S_V_CALC)
            calc_res = calc(pred_v_q, mv_v_q, V_R_SIZE);
        else
            calc_res = calc(pred_h_q, mv_h_q, H_R_SIZE);

        if (state_q == S_H_CALC || state_q == S_V_CALC) begin
            neg_d = calc_res.neg;
            mag_d = calc_res.mag;
            res_d = calc_res.res;
        end
        if (state_q == S_H_CALC)
            out_pred_h_d = $signed(calc_res.recon);
        if (state_q == S_V_CALC)
            out_pred_v_d = mvscale_q ? $signed(calc_res.recon << 1) : $signed(calc_res.recon);

        vlc_res  = vlc(mag_q, neg_q);
        app_bits = '0;
        app_n    = '0;
        case (state_q)
            S_MVFS: if (emit_q) begin
                app_bits = 16'(mvfs_q);
                app_n    = 5'd1;
            end
            S_H_CODE, S_V_CODE: begin
                app_bits = vlc_res.bits;
                app_n    = vlc_res.len;
            end
            S_H_RES: if (H_R_SIZE != 0 && mag_q != 5'd0) begin
                app_bits = 16'(res_q);
                app_n    = 5'(H_R_SIZE);
            end
            S_V_RES: if (V_R_SIZE != 0 && mag_q != 5'd0) begin
                app_bits = 16'(res_q);
                app_n    = 5'(V_R_SIZE);
            end
            default: ;
        endcase

        // Drain first (flush or a full word from last cycle), then append this cycle's bits.
        acc_b            = acc_q;
        fill_b           = fill_q;
        out_word_d       = '0;
        out_nbits_d      = '0;
        out_word_valid_d = 1'b0;
        if (state_q == S_IDLE && flush && fill_q != 7'd0) begin
            out_word_d       = acc_q[63:32];
            out_nbits_d      = 6'(fill_q);
            out_word_valid_d = 1'b1;
            acc_b            = '0;
            fill_b           = '0;
        end else if (fill_q >= 7'd32) begin
            out_word_d       = acc_q[63:32];
            out_nbits_d      = 6'd32;
            out_word_valid_d = 1'b1;
            acc_b            = acc_q << 32;
            fill_b           = fill_q - 7'd32;
        end
        acc_d  = acc_b | (64'(app_bits) << (7'd64 - fill_b - 7'(app_n)));
        fill_d = fill_b + 7'(app_n);
    end

    assign busy           = (state_q != S_IDLE);
    assign out_word       = out_word_q;
    assign out_nbits      = out_nbits_q;
    assign out_word_valid = out_word_valid_q;
    assign out_pred_h     = out_pred_h_q;
    assign out_pred_v     = out_pred_v_q;
    assign done           = done_q;

endmodule

// File: tb/tb_motion_vector_encoder.sv
// Directed bench for motion_vector_encoder: one instance with r_size 0, one with r_size 2.
module tb_motion_vector_encoder;

    logic clk = 1'b0;
    logic rst, in_valid, mvscale, emit_mvfs, mvfs, flush;
    logic signed [31:0] in_pred_h, in_pred_v, in_mv_h, in_mv_v;

    logic        busy0, wv0, done0, busy2, wv2, done2;
    logic [31:0] word0, word2;
    logic [5:0]  nb0, nb2;
    logic signed [31:0] ph0, pv0, ph2, pv2;

    int errors = 0;
    int checks = 0;

    logic [31:0] q0_w[$], q2_w[$];
    logic [5:0]  q0_n[$], q2_n[$];
    int done_cnt0 = 0;

    always #5 clk = ~clk;

    motion_vector_encoder #(.H_R_SIZE(0), .V_R_SIZE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_pred_h(in_pred_h), .in_pred_v(in_pred_v), .in_mv_h(in_mv_h), .in_mv_v(in_mv_v),
        .mvscale(mvscale), .emit_mvfs(emit_mvfs), .mvfs(mvfs), .flush(flush),
        .busy(busy0), .out_word(word0), .out_nbits(nb0), .out_word_valid(wv0),
        .out_pred_h(ph0), .out_pred_v(pv0), .done(done0));

    motion_vector_encoder #(.H_R_SIZE(2), .V_R_SIZE(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_pred_h(in_pred_h), .in_pred_v(in_pred_v), .in_mv_h(in_mv_h), .in_mv_v(in_mv_v),
        .mvscale(mvscale), .emit_mvfs(emit_mvfs), .mvfs(mvfs), .flush(flush),
        .busy(busy2), .out_word(word2), .out_nbits(nb2), .out_word_valid(wv2),
        .out_pred_h(ph2), .out_pred_v(pv2), .done(done2));

    always @(negedge clk) begin
        if (wv0) begin q0_w.push_back(word0); q0_n.push_back(nb0); end
        if (wv2) begin q2_w.push_back(word2); q2_n.push_back(nb2); end
        if (done0) done_cnt0++;
    end

    typedef struct {
        bit                 r2;
        logic signed [31:0] ph, pv, mh, mv;
        bit                 sc, em, fs;
        logic [31:0]        w;
        int                 n;
        logic signed [31:0] eph, epv;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input vec_t e);
        in_pred_h = e.ph; in_pred_v = e.pv; in_mv_h = e.mh; in_mv_v = e.mv;
        mvscale = e.sc; emit_mvfs = e.em; mvfs = e.fs;
    endtask

    task automatic start_and_wait(input bit sel2, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (sel2 ? done2 : done0) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic flush_pulse();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q0_w.delete(); q0_n.delete(); q2_w.delete(); q2_n.delete();
    endtask

    task automatic run_vec(input int i);
        int lat;
        vec_t e;
        e = tbl[i];
        clear_q();
        set_in(e);
        start_and_wait(e.r2, lat);
        check($sformatf("v%0d_latency", i), 64'(lat), 64'd8);
        @(posedge clk);
        #1 check($sformatf("v%0d_done_width", i), 64'(e.r2 ? done2 : done0), 64'd0);
        check($sformatf("v%0d_pred_h", i), 64'(e.r2 ? ph2 : ph0), 64'(e.eph));
        check($sformatf("v%0d_pred_v", i), 64'(e.r2 ? pv2 : pv0), 64'(e.epv));
        flush_pulse();
        if (e.r2) begin
            check($sformatf("v%0d_strobes", i), 64'(q2_w.size()), 64'd1);
            if (q2_w.size() > 0) begin
                check($sformatf("v%0d_word", i), 64'(q2_w[0]), 64'(e.w));
                check($sformatf("v%0d_nbits", i), 64'(q2_n[0]), 64'(e.n));
            end
        end else begin
            check($sformatf("v%0d_strobes", i), 64'(q0_w.size()), 64'd1);
            if (q0_w.size() > 0) begin
                check($sformatf("v%0d_word", i), 64'(q0_w[0]), 64'(e.w));
                check($sformatf("v%0d_nbits", i), 64'(q0_n[0]), 64'(e.n));
            end
        end
    endtask

    initial begin
        logic [22:0]  unit;
        logic [255:0] stream;
        int lat;
        vec_t e;

        //        r2  ph   pv   mh   mv   sc em fs  word          n   eph  epv
        tbl[0] = '{0, 0,   0,   1,   0,   0, 0, 0, 32'h50000000, 4,  1,   0};
        tbl[1] = '{1, 0,   0,   -5,  0,   0, 0, 0, 32'h32000000, 7,  -5,  0};
        tbl[2] = '{0, 10,  0,   -10, 0,   0, 0, 0, 32'h04100000, 12, -10, 0};
        tbl[3] = '{0, 0,   8,   0,   12,  1, 0, 0, 32'h90000000, 5,  0,   12};
        tbl[4] = '{0, 0,   0,   0,   0,   0, 1, 1, 32'hE0000000, 3,  0,   0};
        tbl[5] = '{0, 15,  0,   -16, -3,  0, 0, 0, 32'h43000000, 8,  -16, -3};
        tbl[6] = '{1, 0,   0,   63,  -64, 0, 0, 0, 32'h031019C0, 26, 63,  -64};
        tbl[7] = '{0, 0,   0,   20,  0,   0, 0, 0, 32'h04300000, 12, -12, 0};

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
        set_in(tbl[0]);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_word", 64'(word0), 64'd0);
        check("rst_nbits", 64'(nb0), 64'd0);
        check("rst_valid", 64'(wv0), 64'd0);
        check("rst_pred_h", 64'(ph0), 64'd0);
        check("rst_pred_v", 64'(pv0), 64'd0);
        check("rst_done", 64'(done0), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(i);

        // Flush coinciding with a new request: pending '111' leaves first, then the vector codes.
        clear_q();
        set_in(tbl[4]);
        start_and_wait(1'b0, lat);
        check("coinc_first_latency", 64'(lat), 64'd8);
        @(negedge clk);
        set_in(tbl[0]);
        flush = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        check("coinc_busy", 64'(busy0), 64'd1);
        repeat (9) @(posedge clk);
        #1;
        flush_pulse();
        check("coinc_strobes", 64'(q0_w.size()), 64'd2);
        if (q0_w.size() == 2) begin
            check("coinc_word0", 64'(q0_w[0]), 64'hE0000000);
            check("coinc_nbits0", 64'(q0_n[0]), 64'd3);
            check("coinc_word1", 64'(q0_w[1]), 64'h50000000);
            check("coinc_nbits1", 64'(q0_n[1]), 64'd4);
        end

        // Eight back-to-back code -16 vectors with in_valid held high throughout.
        clear_q();
        unit   = 23'b1_00000011001_00000011001;
        stream = {{8{unit}}, 72'd0};
        e = '{0, 0, 0, -16, -16, 0, 1, 1, 32'h0, 0, -16, -16};
        set_in(e);
        @(negedge clk);
        done_cnt0 = 0;
        in_valid = 1'b1;
        repeat (64) @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 0; k < 40 && done_cnt0 < 8; k++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check("b2b_dones", 64'(done_cnt0), 64'd8);
        check("b2b_full_words", 64'(q0_w.size()), 64'd5);
        check("b2b_pred_h", 64'(ph0), 64'(-32'sd16));
        flush_pulse();
        check("b2b_total_strobes", 64'(q0_w.size()), 64'd6);
        for (int k = 0; k < 6 && k < q0_w.size(); k++) begin
            check($sformatf("b2b_word%0d", k), 64'(q0_w[k]), 64'(stream[255 - 32*k -: 32]));
            check($sformatf("b2b_nbits%0d", k), 64'(q0_n[k]), (k < 5) ? 64'd32 : 64'd24);
        end

        // Reset while in S_H_RES with 20 bits pending discards everything.
        clear_q();
        e = '{0, 0, 0, 0, 4, 0, 0, 0, 32'h0, 0, 0, 4};
        set_in(e);
        start_and_wait(1'b0, lat);
        e = '{0, 0, 0, 12, 0, 0, 1, 0, 32'h0, 0, 12, 0};
        set_in(e);
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_pre_busy", 64'(busy0), 64'd1);
        check("midrst_pre_pred_h", 64'(ph0), 64'd12);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", 64'(busy0), 64'd0);
        check("midrst_pred_h", 64'(ph0), 64'd0);
        check("midrst_pred_v", 64'(pv0), 64'd0);
        check("midrst_word", 64'(word0), 64'd0);
        check("midrst_nbits", 64'(nb0), 64'd0);
        check("midrst_valid", 64'(wv0), 64'd0);
        check("midrst_done", 64'(done0), 64'd0);
        rst = 1'b0;
        flush_pulse();
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_strobe", 64'(q0_w.size()), 64'd0);
        run_vec(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/motion_vector_encoder.md
Name: motion_vector_encoder

Overview:
- Encoder-side counterpart of the motion vector decode path: turns one (horizontal, vertical) motion vector plus its predictors into MPEG-2 motion_code VLC and motion_residual bits.
- Output bits are packed MSB-first into 32-bit words for the bitstream writer.
- Also returns the updated predictors a decoder would reconstruct, so the encoder and decoder PMV state stay in lockstep.

Parameters:
- H_R_SIZE, 3, horizontal r_size (f_code-1), legal 0..8; f = 1<<H_R_SIZE.
- V_R_SIZE, 3, vertical r_size, legal 0..8.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  start request; sampled only in S_IDLE
- in_pred_h  in  32  signed horizontal predictor (PMV[r][s][0])
- in_pred_v  in  32  signed vertical predictor (PMV[r][s][1])
- in_mv_h  in  32  signed horizontal vector to code
- in_mv_v  in  32  signed vertical vector to code
- mvscale  in  1  vertical field/frame scaling enable
- emit_mvfs  in  1  emit motion_vertical_field_select bit first
- mvfs  in  1  field select bit value
- flush  in  1  force out a partial word; honoured only in S_IDLE
- busy  out  1  high in every state except S_IDLE
- out_word  out  32  packed bits, MSB first
- out_nbits  out  6  valid bits in out_word (1..32), left-aligned
- out_word_valid  out  1  one-cycle strobe
- out_pred_h  out  32  reconstructed horizontal predictor
- out_pred_v  out  32  reconstructed vertical predictor
- done  out  1  one-cycle completion strobe

Behaviour:
- Reset: every output is 0; the 64-bit accumulator and fill count are 0; state is S_IDLE. Reset mid-operation discards pending bits and the in-flight vector without emitting anything.
- FSM: S_IDLE -> S_MVFS -> S_H_CALC -> S_H_CODE -> S_H_RES -> S_V_CALC -> S_V_CODE -> S_V_RES -> S_DONE -> S_IDLE. Each state lasts exactly one cycle, except S_IDLE, which waits.
- in_valid in S_IDLE latches all inputs, and latency is fixed: done=1 for exactly one cycle, 8 cycles after the accepting edge. in_valid outside S_IDLE is ignored.
- If in_valid and flush arrive together in S_IDLE, flush is performed first in that cycle and the vector is then accepted.
- Vertical scaling: if mvscale=1, predictor = in_pred_v>>>1 and vector = in_mv_v>>>1, both arithmetic shifts. out_pred_v = reconstructed<<1.
- CALC, per component (r = r_size, f = 1<<r):
  - delta = mv - pred.
  - If delta < -16f, add 32f. Else if delta > 16f-1, subtract 32f.
  - delta=0 gives code=0 and no residual.
  - Otherwise code = ((|delta|-1)>>r)+1, residual = (|delta|-1) & (f-1), and the code is negative when delta<0.
  - Reconstructed = pred+delta, wrapped into [-16f, 16f-1]; it is registered to out_pred_* in CALC.
- CODE: appends the VLC for |code|, with a trailing sign bit (0 positive, 1 negative) when code≠0:
  - 0:'1'
  - 1:'01s'
  - 2:'001s'
  - 3:'0001s'
  - 4:'000011s'
  - 5:'0000101s'
  - 6:'0000100s'
  - 7:'0000011s'
  - 8:'000001011s'
  - 9:'000001010s'
  - 10:'000001001s'
  - 11:'0000010001s'
  - 12:'0000010000s'
  - 13:'0000001111s'
  - 14:'0000001110s'
  - 15:'0000001101s'
  - 16:'0000001100s'
- RES: appends r residual bits, MSB first, only when r≠0 and code≠0; otherwise it appends 0 bits (the cycle is still spent).
- S_MVFS: appends mvfs when emit_mvfs=1; otherwise it appends 0 bits.
- Packer: up to 16 bits are appended per cycle.
  - When the fill reaches ≥32, the top 32 bits go out with out_nbits=32 and out_word_valid=1 in the following cycle, and the remainder shifts up.
  - A fill of exactly 32 leaves 0 bits pending.
  - There is no backpressure; the consumer must accept every strobe.
- Flush (S_IDLE, fill>0): out_word = pending bits left-aligned and zero-padded, out_nbits = fill, strobe 1 cycle, then fill=0. Flush with fill=0 produces no strobe.
- An input vector outside [-16f, 16f-1] of its predictor still encodes. The predictor returned is the wrapped value, not the input.

Test Plan:
1. H_R_SIZE=V_R_SIZE=0, pred=(0,0), mv=(1,0), emit_mvfs=0, then flush -> out_word=0x50000000, out_nbits=4 ('010','1'), out_pred=(1,0), done 8 cycles after accept.
2. H_R_SIZE=2, pred_h=0, mv_h=-5, V_R_SIZE=2, mv_v=pred_v=0 -> h bits '0011'+'00', v bit '1'; flush gives out_word=0x32000000, nbits=7; out_pred_h=-5.
3. H_R_SIZE=0, pred_h=10, mv_h=-10 -> delta wraps to +12, bits '00000100000', out_pred_h=-10.
4. mvscale=1, pred_v=8, mv_v=12, V_R_SIZE=0 -> scaled delta +2, bits '0010', out_pred_v=12.
5. Eight back-to-back vectors with code ±16 on both components and emit_mvfs=1 (23 bits each, 184 total) -> five strobes with nbits=32 and correct bit order, then flush with nbits=24. in_valid held high is taken only in S_IDLE.
6. Assert rst in S_H_RES with 20 bits pending -> all outputs 0 next cycle; a following flush produces no strobe.
